// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encodings, the UART store address, the default baud divisor and a parity helper.
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
        UART_ST_PARITY = 3'd3,
        UART_ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [31:0] UART_ADDR = 32'h1000_0000;

    // 50 MHz core clock divided down to 115200 baud.
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous circular-buffer FIFO. Pushes while full and pops while empty are ignored.
// The read data is the entry at the read pointer and is valid whenever empty is low.
module uart_tx_buffered_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Both flags come from the registered count, so a pop in the same cycle
    // never makes room for a push that arrives while full.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: CPU stores queue in a FIFO and are serialized LSB first.
// 8N1 by default; defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 16,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(CLKS_PER_BIT)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        ovf_clr,
    output logic        tx,
    output logic        full,
    output logic [AW:0] level,
    output logic        busy,
    output logic        overflow
);

    uart_state_e  state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    fifo_data;
    logic          fifo_empty;
    logic          baud_done;
    logic          pop;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign baud_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // A new byte is taken either from idle or exactly at the end of a stop bit,
    // which is what keeps back-to-back frames contiguous.
    assign pop  = !fifo_empty && ((state == UART_ST_IDLE) || ((state == UART_ST_STOP) && baud_done));
    assign busy = (state != UART_ST_IDLE) || !fifo_empty;

    uart_tx_buffered_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (full),
        .empty     (fifo_empty),
        .count     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= UART_ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                UART_ST_IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        par   <= even_parity(fifo_data);
`endif
                        tx    <= 1'b0;
                        state <= UART_ST_START;
                    end
                end
                UART_ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= UART_ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                UART_ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= UART_ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= UART_ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                UART_ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= UART_ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif
                UART_ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
                            par   <= even_parity(fifo_data);
`endif
                            tx    <= 1'b0;
                            state <= UART_ST_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= UART_ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    state    <= UART_ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed scenarios plus random pushes,
// checked every cycle against a frame-timeline reference model.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          tx;
    logic          full;
    logic [LW-1:0] level;
    logic          busy;
    logic          overflow;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .full     (full),
        .level    (level),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int cyc;
    int dut_peak;

    // Reference model: queued bytes plus the timeline of the frame on the line.
    logic [7:0] exp_q[$];
    int         m_level;
    logic       m_ovf;
    int         last_end;
    int         cur_start;
    logic [7:0] cur_byte;
    logic       have_frame;

    function automatic logic model_tx();
        int k;
        if (!have_frame || cyc >= cur_start + FRAME) return 1'b1;
        k = (cyc - cur_start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur_byte[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^cur_byte;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_level    = 0;
        m_ovf      = 1'b0;
        last_end   = 0;
        cur_start  = 0;
        cur_byte   = 8'h00;
        have_frame = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] d, input logic clr);
        int lvl_before;
        logic dropped;
        lvl_before = m_level;
        dropped    = we && (lvl_before == DEPTH);
        if (cyc >= last_end && lvl_before > 0) begin
            cur_byte   = exp_q.pop_front();
            cur_start  = cyc;
            last_end   = cyc + FRAME;
            have_frame = 1'b1;
            m_level--;
        end
        if (we && !dropped) begin
            exp_q.push_back(d);
            m_level++;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        if (32'(level) > dut_peak) dut_peak = 32'(level);
        check("tx", 32'(tx), 32'(model_tx()));
        check("level", 32'(level), 32'(m_level));
        check("full", 32'(full), 32'(m_level == DEPTH));
        check("busy", 32'(busy), 32'((cyc < last_end) || (m_level != 0)));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called at a falling edge; applies inputs across one rising edge and checks.
    task automatic tick(input logic we, input logic [7:0] d, input logic clr);
        wr_en   = we;
        wr_data = d;
        ovf_clr = clr;
        @(posedge clk);
        cyc++;
        model_edge(we, d, clr);
        @(negedge clk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (((cyc < last_end) || (m_level != 0)) && guard < 2000) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        check(tag, 32'(guard < 2000), 32'd1);
        idle(2);
    endtask

    initial begin
        int guard;
        n_cmp    = 0;
        n_err    = 0;
        cyc      = 0;
        dut_peak = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        ovf_clr  = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single byte: start bit appears one edge after the accepting edge.
        tick(1'b1, 8'h55, 1'b0);
        check("single_pre_start", 32'(tx), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        check("single_start", 32'(tx), 32'd0);
        idle(FRAME + 2);
        check("single_done_busy", 32'(busy), 32'd0);
        check("single_done_level", 32'(level), 32'd0);

        // Burst of three consecutive stores.
        dut_peak = 0;
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        tick(1'b1, 8'h03, 1'b0);
        drain("burst_drain");
        check("burst_peak", 32'(dut_peak), 32'd2);

        // Overflow: six back-to-back stores into a 4-deep FIFO.
        repeat (6) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'(DEPTH));
        tick(1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Push while full on the edge that ends STOP and pops.
        guard = 0;
        while (cyc + 1 != last_end && guard < 200) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        check("pf_reached", 32'(guard < 200), 32'd1);
        tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        check("pf_level", 32'(level), 32'(DEPTH - 1));
        check("pf_ovf", 32'(overflow), 32'd1);
        drain("pf_drain");
        tick(1'b0, 8'h00, 1'b1);

        // Parity-relevant bytes (odd and even number of ones).
        tick(1'b1, 8'h07, 1'b0);
        tick(1'b1, 8'h03, 1'b0);
        drain("par_drain");

        // Random traffic with occasional overflow and clears.
        repeat (400) begin
            tick(logic'($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 15) == 0));
        end
        drain("rand_drain");

        // Reset in the middle of data bit 3 with bytes still queued.
        tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        guard = 0;
        while (!(have_frame && cyc < last_end && (cyc - cur_start) / CPB == 4) && guard < 200) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        check("mr_reached", 32'(guard < 200), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_tx", 32'(tx), 32'd1);
        check("mr_level", 32'(level), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        tick(1'b1, 8'hA5, 1'b0);
        drain("mr_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Buffered 8N1 UART transmitter that sits directly downstream of the CPU memory-access stage.
- Takes the byte written by a store to the UART address and queues it in a FIFO.
- Serializes queued bytes onto the FPGA TX pin at a fixed baud rate.
- Decouples the single-cycle core, which can store every cycle, from the slow serial line.
- Exposes full/level/overflow status so software can poll before storing.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥2.
DEPTH, 16, FIFO entries; must be a power of 2, ≥2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  push request (store to UART address)
wr_data  in  8  byte to transmit
ovf_clr  in  1  clears sticky overflow flag
tx  out  1  serial output, idle high
full  out  1  FIFO holds DEPTH bytes
level  out  log2(DEPTH)+1  bytes currently queued (excludes byte being shifted)
busy  out  1  frame in progress or FIFO non-empty
overflow  out  1  sticky: a push was dropped

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - tx=1, full=0, level=0, busy=0, overflow=0.
  - FSM=IDLE; FIFO pointers and count=0; baud counter=0; bit index=0.
- Reset mid-frame: tx returns to 1 immediately (async). The partial frame and all queued bytes are discarded.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus count of log2(DEPTH)+1 bits.
  - full = (count==DEPTH); level = count.
- Push:
  - On a clk edge with wr_en=1 and full=0, store wr_data at wr_ptr, increment wr_ptr, increment count.
  - wr_en=1 while full=1 drops the byte and sets overflow. This holds even if a pop happens the same cycle, because full is the registered value.
- Pop:
  - Happens when the FSM in IDLE, or at the end of STOP, sees count≠0.
  - The FSM loads the shift register from rd_ptr, increments rd_ptr and decrements count.
- Simultaneous push+pop (not full): count unchanged; both pointers advance.
- A push into an empty FIFO cannot pop in the same cycle. The earliest pop is the following edge.
- overflow: set by a dropped push; cleared by ovf_clr=1. If set and clear occur in the same cycle, set wins.
- FSM states and transitions:
  - IDLE: tx=1. If count≠0, pop and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count≠0, pop and go directly to START with no idle gap; else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state/bit transition.
- tx is registered (glitch-free).
- Latency: a push accepted at edge N into an empty FIFO with the FSM idle gives tx=0 from edge N+1.
- Frame timing: one frame is 10×CLKS_PER_BIT cycles; back-to-back frames are contiguous.
- busy = (state≠IDLE) || (count≠0).

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds state PARITY between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11×CLKS_PER_BIT (8E1).
- Undefined: no PARITY state; 8N1 with a 10-bit frame.

Decomposition:
- Shared header (define.vh) holds:
  - FSM state encodings UART_ST_IDLE/START/DATA/PARITY/STOP.
  - UART_ADDR.
  - Default CLKS_PER_BIT.
- One natural sub-module: sync_fifo (parameterized width/depth; push/pop/full/empty/count), instantiated with width 8.
- The serializer FSM stays in uart_tx_buffered.

Test Plan:
- Single byte: with CLKS_PER_BIT=4, push 0x55 into an idle block → tx low from the next edge, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then stop high. Frame is 40 cycles; busy=0 afterwards; level=0.
- Burst: push 0x01,0x02,0x03 on consecutive cycles → level peaks at 2. Three contiguous 40-cycle frames with no idle cycle between stop and the next start.
- Overflow: with DEPTH=4, push 6 bytes back-to-back while idle → 5 accepted (1 popped + 4 queued), 6th dropped. full=1 and overflow=1; ovf_clr pulse returns overflow to 0.
- Push while full with simultaneous pop at end of STOP → push is dropped, overflow=1, level drops to DEPTH-1.
- Mid-frame reset: assert rst_n=0 during DATA bit 3 → tx=1 immediately; level=0, busy=0. Pushing 0xA5 after release transmits a clean frame.
- With UART_TX_PARITY_EN: push 0x07 → parity bit 1, frame is 44 cycles. Push 0x03 → parity bit 0.
